coin_credit_accumulator: RTL and testbench
==========================================

Name: coin_credit_accumulator

Overview:
Parametrised successor to the Lab5 coin acceptor (myCoinFSM). It accepts coins of three configurable values and accumulates them toward a configurable game price. It banks completed games up to a configurable maximum and returns coins once the bank is full. It consumes one banked game per start request. It sits between the coin inputs and the game FSM, and feeds NumGames to the game-start logic.

Parameters:
COIN1_VAL, 1, credit value of CoinValue=2'b01
COIN2_VAL, 2, credit value of CoinValue=2'b10
COIN3_VAL, 4, credit value of CoinValue=2'b11
GAME_PRICE, 4, credit units per game; must be >=2; every COINn_VAL must be <=GAME_PRICE
MAX_GAMES, 7, maximum banked games; must be >=1
GAMES_W, $clog2(MAX_GAMES+1), width of NumGames (derived)
CREDIT_W, $clog2(GAME_PRICE), width of Credit (derived)

Ports:
clock  input  1  system clock; all state updates on posedge
reset  input  1  asynchronous, active-high reset
CoinValue  input  2  coin type; 2'b00 means no coin
CoinInserted  input  1  level; high while a coin is in the slot
ConsumeGame  input  1  one-cycle request to spend one banked game
NumGames  output  GAMES_W  banked games
Credit  output  CREDIT_W  partial credit toward the next game, range 0..GAME_PRICE-1
Drop  output  1  one-cycle pulse: a game was banked
CoinReturn  output  1  one-cycle pulse: a coin was rejected
Full  output  1  high when NumGames==MAX_GAMES

Behaviour:
- Reset (async, active-high):
  - NumGames=0, Credit=0, Drop=0, CoinReturn=0.
  - FSM goes to HELD.
- FSM, two states:
  - IDLE: if CoinInserted=1, process one coin event and go to HELD.
  - HELD: stay in HELD until CoinInserted=0, then go to IDLE.
  - Result: exactly one coin event per CoinInserted assertion, however long it is held.
  - Resetting into HELD means a coin held across reset release is ignored until CoinInserted drops and rises again.
- Coin event with CoinValue=00: no effect on any output; the FSM still moves to HELD.
- Coin event, value v (mapped from COINn_VAL), sum = Credit+v:
  - Effective fullness: fullEff = (NumGames==MAX_GAMES) && !(ConsumeGame && NumGames>0).
  - fullEff=1: reject. Pulse CoinReturn; Credit and NumGames unchanged except for the consume.
  - sum>=GAME_PRICE: Credit<=sum-GAME_PRICE; bank one game; pulse Drop.
  - otherwise: Credit<=sum.
  - The parameter constraint guarantees at most one game per coin.
- ConsumeGame:
  - NumGames>0: decrement by 1.
  - NumGames==0: ignored.
  - A bank and a consume in the same cycle give a net NumGames change of 0.
- Latency and pulse timing:
  - All outputs are registered.
  - Drop and CoinReturn go high the cycle after the posedge where IDLE sees CoinInserted=1, and last exactly one cycle.
  - NumGames and Credit update at that same posedge.
- Full is combinational from registered NumGames.
- Arithmetic:
  - The sum is computed at CREDIT_W+1 bits minimum, with no truncation before the compare.
  - NumGames never exceeds MAX_GAMES and never underflows.
- CoinValue is sampled only on the IDLE-to-HELD cycle; changes while in HELD are ignored.
- Reset mid-operation: outputs clear immediately, without waiting for a clock; partial credit is lost.

Test Plan:
- Reset, then CoinValue=01 with CoinInserted held high for 10 cycles -> one event only: Credit=1, NumGames=0, no Drop.
- Four separate 01 pulses -> Credit goes 1,2,3,0; Drop pulses once on the 4th; NumGames=1.
- Pulses of 01, 10, 11 -> Credit goes 1, 3, then 3 (sum 7-4); NumGames=1; one Drop, on the 11 pulse.
- From reset, seven 11 pulses -> seven Drops, NumGames=7, Full=1; 8th 11 pulse -> CoinReturn pulse, no Drop, NumGames=7, Credit=0.
- Full (NumGames=7), 11 pulse with ConsumeGame=1 in the same cycle -> Drop, no CoinReturn, NumGames=7; ConsumeGame at NumGames=0 -> stays 0.
- Credit=2, assert reset asynchronously mid-cycle while CoinInserted=1 -> outputs clear before the next posedge; after release, the held coin is not counted; drop and re-raise CoinInserted with 01 -> Credit=1.

Source files
------------

// File: rtl/coin_credit_accumulator_if.sv
// -----------------------------------------------------------------------------
// coin_credit_accumulator_if
//
// Purpose:
//   Groups the coin-side inputs and the credit/game outputs of the coin credit
//   accumulator into one bundle. Clock and reset are not carried here; they
//   stay as plain ports on the modules.
//
// Signals:
//   CoinValue    [1:0]          coin type, 2'b00 = no coin
//   CoinInserted                level, high while a coin sits in the slot
//   ConsumeGame                 one-cycle request to spend one banked game
//   NumGames     [GAMES_W-1:0]  number of banked games
//   Credit       [CREDIT_W-1:0] partial credit toward the next game
//   Drop                        one-cycle pulse, a game was banked
//   CoinReturn                  one-cycle pulse, a coin was rejected
//   Full                        high while the game bank is full
//
// Modports:
//   master : coin mechanism / game logic side (drives the requests)
//   slave  : the accumulator itself (drives credit and game status)
// -----------------------------------------------------------------------------
interface coin_credit_accumulator_if #(
    parameter int GAMES_W  = 3,
    parameter int CREDIT_W = 2
);
    logic [1:0]          CoinValue;
    logic                CoinInserted;
    logic                ConsumeGame;
    logic [GAMES_W-1:0]  NumGames;
    logic [CREDIT_W-1:0] Credit;
    logic                Drop;
    logic                CoinReturn;
    logic                Full;

    modport master (
        output CoinValue,
        output CoinInserted,
        output ConsumeGame,
        input  NumGames,
        input  Credit,
        input  Drop,
        input  CoinReturn,
        input  Full
    );

    modport slave (
        input  CoinValue,
        input  CoinInserted,
        input  ConsumeGame,
        output NumGames,
        output Credit,
        output Drop,
        output CoinReturn,
        output Full
    );
endinterface

// File: rtl/coin_credit_accumulator.sv
// -----------------------------------------------------------------------------
// coin_credit_accumulator
//
// Purpose:
//   Accepts coins of three configurable values and accumulates them toward a
//   configurable game price. Completed games are banked up to MAX_GAMES; once
//   the bank is full further coins are returned. One banked game is spent per
//   ConsumeGame request. Each assertion of CoinInserted yields exactly one coin
//   event, however long the coin is held.
//
// Ports:
//   clock  input   system clock, all state updates on the rising edge
//   reset  input   asynchronous, active-high reset
//   bus    slave   coin_credit_accumulator_if (coin inputs, ConsumeGame,
//                  NumGames, Credit, Drop, CoinReturn, Full)
//
// Parameters:
//   COIN1_VAL/COIN2_VAL/COIN3_VAL  credit value of CoinValue 01/10/11
//   GAME_PRICE                     credit units per game (>= 2, >= every coin)
//   MAX_GAMES                      maximum banked games (>= 1)
//   GAMES_W, CREDIT_W              derived widths of NumGames and Credit
// -----------------------------------------------------------------------------
module coin_credit_accumulator #(
    parameter int COIN1_VAL  = 1,
    parameter int COIN2_VAL  = 2,
    parameter int COIN3_VAL  = 4,
    parameter int GAME_PRICE = 4,
    parameter int MAX_GAMES  = 7,
    parameter int GAMES_W    = $clog2(MAX_GAMES + 1),
    parameter int CREDIT_W   = $clog2(GAME_PRICE)
) (
    input  logic                        clock,
    input  logic                        reset,
    coin_credit_accumulator_if.slave    bus
);

    // One extra bit over Credit: Credit <= GAME_PRICE-1 and a coin is worth at
    // most GAME_PRICE, so the sum stays below 2*GAME_PRICE <= 2^(CREDIT_W+1).
    localparam int SUM_W = CREDIT_W + 1;

    localparam logic [SUM_W-1:0]   PRICE_S   = SUM_W'(GAME_PRICE);
    localparam logic [SUM_W-1:0]   COIN1_S   = SUM_W'(COIN1_VAL);
    localparam logic [SUM_W-1:0]   COIN2_S   = SUM_W'(COIN2_VAL);
    localparam logic [SUM_W-1:0]   COIN3_S   = SUM_W'(COIN3_VAL);
    localparam logic [GAMES_W-1:0] MAX_G     = GAMES_W'(MAX_GAMES);
    localparam logic [GAMES_W-1:0] ZERO_G    = '0;
    localparam logic [GAMES_W-1:0] ONE_G     = GAMES_W'(1);

    typedef enum logic {
        IDLE = 1'b0,
        HELD = 1'b1
    } state_t;

    state_t              stateReg;
    state_t              stateNext;

    logic [CREDIT_W-1:0] creditReg;
    logic [CREDIT_W-1:0] creditNext;
    logic [GAMES_W-1:0]  numGamesReg;
    logic [GAMES_W-1:0]  numGamesNext;
    logic                dropReg;
    logic                dropNext;
    logic                coinReturnReg;
    logic                coinReturnNext;

    logic                coinEvent;
    logic [SUM_W-1:0]    coinVal;
    logic [SUM_W-1:0]    sum;
    logic                consumeOk;
    logic                fullEff;
    logic                bankGame;

    // ------------------------------------------------------------------
    // FSM: state register
    // Reset lands in HELD so a coin held across reset release is ignored
    // until the slot is cleared and re-entered.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stateReg <= HELD;
        end else begin
            stateReg <= stateNext;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and coin-event detection
    // ------------------------------------------------------------------
    always_comb begin
        stateNext = stateReg;
        coinEvent = 1'b0;
        case (stateReg)
            IDLE: begin
                if (bus.CoinInserted) begin
                    coinEvent = 1'b1;
                    stateNext = HELD;
                end
            end
            HELD: begin
                if (!bus.CoinInserted) begin
                    stateNext = IDLE;
                end
            end
            default: begin
                stateNext = HELD;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Coin value mapping (00 = no coin, worth nothing)
    // ------------------------------------------------------------------
    always_comb begin
        coinVal = '0;
        case (bus.CoinValue)
            2'b01:   coinVal = COIN1_S;
            2'b10:   coinVal = COIN2_S;
            2'b11:   coinVal = COIN3_S;
            default: coinVal = '0;
        endcase
    end

    assign sum = {1'b0, creditReg} + coinVal;

    // A consume in the same cycle frees a slot, so a coin arriving while the
    // bank is nominally full is still accepted.
    assign consumeOk = bus.ConsumeGame && (numGamesReg != ZERO_G);
    assign fullEff   = (numGamesReg == MAX_G) && !consumeOk;

    // ------------------------------------------------------------------
    // Credit / game datapath next-state
    // ------------------------------------------------------------------
    always_comb begin
        creditNext     = creditReg;
        dropNext       = 1'b0;
        coinReturnNext = 1'b0;
        bankGame       = 1'b0;

        if (coinEvent && (bus.CoinValue != 2'b00)) begin
            if (fullEff) begin
                coinReturnNext = 1'b1;
            end else if (sum >= PRICE_S) begin
                // Each coin is worth at most one game, so one subtraction
                // always brings the remainder back into 0..GAME_PRICE-1.
                creditNext = CREDIT_W'(sum - PRICE_S);
                bankGame   = 1'b1;
                dropNext   = 1'b1;
            end else begin
                creditNext = CREDIT_W'(sum);
            end
        end
    end

    // Bank and consume in the same cycle cancel out. Banking only happens when
    // the bank is below MAX_GAMES or a consume is freeing a slot, and a
    // consume only when the bank is non-empty, so no overflow or underflow.
    always_comb begin
        numGamesNext = numGamesReg;
        case ({bankGame, consumeOk})
            2'b10:   numGamesNext = numGamesReg + ONE_G;
            2'b01:   numGamesNext = numGamesReg - ONE_G;
            default: numGamesNext = numGamesReg;
        endcase
    end

    // ------------------------------------------------------------------
    // Registered outputs; reset clears them without waiting for a clock
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            creditReg     <= '0;
            numGamesReg   <= '0;
            dropReg       <= 1'b0;
            coinReturnReg <= 1'b0;
        end else begin
            creditReg     <= creditNext;
            numGamesReg   <= numGamesNext;
            dropReg       <= dropNext;
            coinReturnReg <= coinReturnNext;
        end
    end

    assign bus.Credit     = creditReg;
    assign bus.NumGames   = numGamesReg;
    assign bus.Drop       = dropReg;
    assign bus.CoinReturn = coinReturnReg;
    assign bus.Full       = (numGamesReg == MAX_G);

endmodule

// File: tb/tb_coin_credit_accumulator.sv
`timescale 1ns/1ps
module tb_coin_credit_accumulator;

    logic clock;
    logic reset;
    int   errors;
    int   checks;

    coin_credit_accumulator_if #(.GAMES_W(3), .CREDIT_W(2)) bus ();

    coin_credit_accumulator #(
        .COIN1_VAL  (1),
        .COIN2_VAL  (2),
        .COIN3_VAL  (4),
        .GAME_PRICE (4),
        .MAX_GAMES  (7)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #10 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic checkAll(input string tag, input logic drop, input logic ret,
                            input int credit, input int games);
        check({tag, ".Drop"},       {31'd0, bus.Drop},       {31'd0, drop});
        check({tag, ".CoinReturn"}, {31'd0, bus.CoinReturn}, {31'd0, ret});
        check({tag, ".Credit"},     {30'd0, bus.Credit},     credit);
        check({tag, ".NumGames"},   {29'd0, bus.NumGames},   games);
        $display("txn %s: Drop=%0b CoinReturn=%0b Credit=%0d NumGames=%0d Full=%0b",
                 tag, bus.Drop, bus.CoinReturn, bus.Credit, bus.NumGames, bus.Full);
    endtask

    // Synchronous-looking reset pulse; FSM ends up IDLE afterwards (slot empty).
    task automatic doReset();
        @(negedge clock);
        reset = 1'b1;
        #1;
        checkAll("reset", 1'b0, 1'b0, 0, 0);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
    endtask

    // One coin insertion, optionally with a consume on the event cycle.
    task automatic coinPulse(input string tag, input logic [1:0] v, input logic consume,
                             input logic drop, input logic ret, input int credit, input int games);
        @(negedge clock);
        bus.CoinValue    = v;
        bus.CoinInserted = 1'b1;
        bus.ConsumeGame  = consume;
        @(posedge clock);
        #1;
        bus.ConsumeGame = 1'b0;
        checkAll(tag, drop, ret, credit, games);
        @(negedge clock);
        bus.CoinInserted = 1'b0;
        @(posedge clock);
        #1;
        check({tag, ".DropOneCycle"},   {31'd0, bus.Drop},       32'd0);
        check({tag, ".ReturnOneCycle"}, {31'd0, bus.CoinReturn}, 32'd0);
    endtask

    task automatic consumeOnly(input string tag, input int games);
        @(negedge clock);
        bus.ConsumeGame = 1'b1;
        @(posedge clock);
        #1;
        bus.ConsumeGame = 1'b0;
        check({tag, ".NumGames"}, {29'd0, bus.NumGames}, games);
        $display("txn %s: NumGames=%0d Full=%0b", tag, bus.NumGames, bus.Full);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        errors           = 0;
        checks           = 0;
        reset            = 1'b1;
        bus.CoinValue    = 2'b00;
        bus.CoinInserted = 1'b0;
        bus.ConsumeGame  = 1'b0;

        // Reset state
        #5;
        checkAll("por", 1'b0, 1'b0, 0, 0);
        check("por.Full", {31'd0, bus.Full}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);

        // 1) Coin held for 10 cycles counts once; CoinValue change while held ignored
        @(negedge clock);
        bus.CoinValue    = 2'b01;
        bus.CoinInserted = 1'b1;
        @(posedge clock);
        #1;
        checkAll("hold.first", 1'b0, 1'b0, 1, 0);
        @(negedge clock);
        bus.CoinValue = 2'b11;
        repeat (9) @(posedge clock);
        #1;
        checkAll("hold.end", 1'b0, 1'b0, 1, 0);
        @(negedge clock);
        bus.CoinInserted = 1'b0;
        @(posedge clock);

        // 2) Four 01 coins
        doReset();
        coinPulse("c01.1", 2'b01, 1'b0, 1'b0, 1'b0, 1, 0);
        coinPulse("c01.2", 2'b01, 1'b0, 1'b0, 1'b0, 2, 0);
        coinPulse("c01.3", 2'b01, 1'b0, 1'b0, 1'b0, 3, 0);
        coinPulse("c01.4", 2'b01, 1'b0, 1'b1, 1'b0, 0, 1);

        // 3) Mixed coins 01, 10, 11, then a 00 event that changes nothing
        doReset();
        coinPulse("mix.01", 2'b01, 1'b0, 1'b0, 1'b0, 1, 0);
        coinPulse("mix.10", 2'b10, 1'b0, 1'b0, 1'b0, 3, 0);
        coinPulse("mix.11", 2'b11, 1'b0, 1'b1, 1'b0, 3, 1);
        coinPulse("mix.00", 2'b00, 1'b0, 1'b0, 1'b0, 3, 1);

        // 4) Fill the bank, then reject
        doReset();
        for (int i = 1; i <= 7; i++) begin
            coinPulse($sformatf("fill.%0d", i), 2'b11, 1'b0, 1'b1, 1'b0, 0, i);
        end
        check("fill.Full", {31'd0, bus.Full}, 32'd1);
        coinPulse("reject", 2'b11, 1'b0, 1'b0, 1'b1, 0, 7);
        check("reject.Full", {31'd0, bus.Full}, 32'd1);

        // 5) Coin plus consume while full is accepted; drain; consume at zero
        coinPulse("fullConsume", 2'b11, 1'b1, 1'b1, 1'b0, 0, 7);
        consumeOnly("drain.6", 6);
        check("drain.Full", {31'd0, bus.Full}, 32'd0);
        for (int g = 5; g >= 0; g--) begin
            consumeOnly($sformatf("drain.%0d", g), g);
        end
        consumeOnly("consumeAtZero", 0);

        // 6) Asynchronous reset mid-cycle with a coin in the slot
        doReset();
        coinPulse("pre.11", 2'b11, 1'b0, 1'b1, 1'b0, 0, 1);
        coinPulse("pre.10", 2'b10, 1'b0, 1'b0, 1'b0, 2, 1);
        @(posedge clock);
        #3;
        bus.CoinValue    = 2'b01;
        bus.CoinInserted = 1'b1;
        #2;
        reset = 1'b1;
        #2;
        checkAll("asyncReset", 1'b0, 1'b0, 0, 0);
        @(negedge clock);
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        checkAll("heldIgnored", 1'b0, 1'b0, 0, 0);
        @(negedge clock);
        bus.CoinInserted = 1'b0;
        @(posedge clock);
        coinPulse("reinsert", 2'b01, 1'b0, 1'b0, 1'b0, 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
